// File: rtl/stg_ia.sv
// Instruction-address stage: owns the PC and feeds IF a PC plus a valid flag each cycle.
// Defining STG_IA_BTB_EN adds a direct-mapped branch target buffer for next-PC prediction.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module stg_ia #(
  parameter logic [`SIZE_ADDR-1:0] RESET_PC    = '0,
  parameter int                    BTB_ENTRIES = 4
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_stall,
  input  logic                  iw_redirect,
  input  logic [`SIZE_ADDR-1:0] iw_redirect_pc,
  input  logic                  iw_halt,
  input  logic                  iw_btb_we,
  input  logic                  iw_btb_inval,
  input  logic [`SIZE_ADDR-1:0] iw_btb_pc,
  input  logic [`SIZE_ADDR-1:0] iw_btb_target,
  output logic [`SIZE_ADDR-1:0] ow_mem_addr,
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic                  ow_ia_valid,
  output logic                  ow_pred_taken,
  output logic [`SIZE_ADDR-1:0] ow_pred_target
);
  localparam int AW = `SIZE_ADDR;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_RUN   = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   pc_q, pc_d;
  logic            valid_q, valid_d;
  logic            pred_hit;
  logic [AW-1:0]   pred_tgt;

`ifdef STG_IA_BTB_EN
  localparam int IW = $clog2(BTB_ENTRIES);
  localparam int TW = AW - IW;

  logic [BTB_ENTRIES-1:0] btb_valid_q, btb_valid_d;
  logic [TW-1:0]          btb_tag_q [BTB_ENTRIES];
  logic [AW-1:0]          btb_tgt_q [BTB_ENTRIES];
  logic [IW-1:0]          rd_idx, wr_idx;
  logic [TW-1:0]          rd_tag, wr_tag;

  assign rd_idx = pc_q[IW-1:0];
  assign rd_tag = pc_q[AW-1:IW];
  assign wr_idx = iw_btb_pc[IW-1:0];
  assign wr_tag = iw_btb_pc[AW-1:IW];

  assign pred_hit = btb_valid_q[rd_idx] && (btb_tag_q[rd_idx] == rd_tag);
  assign pred_tgt = pred_hit ? btb_tgt_q[rd_idx] : '0;

  // A write overrides a same-cycle invalidate; invalidate only drops a matching tag.
  always_comb begin
    btb_valid_d = btb_valid_q;
    if (iw_btb_we)
      btb_valid_d[wr_idx] = 1'b1;
    else if (iw_btb_inval && (btb_tag_q[wr_idx] == wr_tag))
      btb_valid_d[wr_idx] = 1'b0;
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) btb_valid_q <= '0;
    else        btb_valid_q <= btb_valid_d;
  end

  genvar gi;
  generate
    for (gi = 0; gi < BTB_ENTRIES; gi++) begin : g_btb
      always_ff @(posedge iw_clk) begin
        if (!iw_rst && iw_btb_we && (wr_idx == IW'(gi))) begin
          btb_tag_q[gi] <= wr_tag;
          btb_tgt_q[gi] <= iw_btb_target;
        end
      end
    end
  endgenerate
`else
  localparam int unused_btb_entries = BTB_ENTRIES;
  logic unused_btb_in;
  assign unused_btb_in = ^{iw_btb_we, iw_btb_inval, iw_btb_pc, iw_btb_target};
  assign pred_hit = 1'b0;
  assign pred_tgt = '0;
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    valid_d = valid_q;
    case (state_q)
      S_RESET: begin
        state_d = S_RUN;
        pc_d    = RESET_PC;
        valid_d = 1'b1;
      end
      S_RUN: begin
        if (iw_redirect) begin
          pc_d    = iw_redirect_pc;
          valid_d = 1'b1;
        end else if (iw_halt) begin
          state_d = S_HALT;
          valid_d = 1'b0;
        end else if (iw_stall) begin
          pc_d = pc_q;
        end else if (pred_hit) begin
          pc_d = pred_tgt;
        end else begin
          pc_d = pc_q + 1'b1;
        end
      end
      S_HALT: begin
        if (iw_redirect) begin
          state_d = S_RUN;
          pc_d    = iw_redirect_pc;
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = S_RESET;
        pc_d    = RESET_PC;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      state_q <= S_RESET;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      valid_q <= valid_d;
    end
  end

  assign ow_pc          = pc_q;
  assign ow_mem_addr    = pc_q;
  assign ow_ia_valid    = valid_q;
  assign ow_pred_taken  = pred_hit;
  assign ow_pred_target = pred_tgt;
endmodule

// File: tb/tb_stg_ia.sv
// Self-checking bench for stg_ia: directed sequence, literal expectations and a per-cycle model compare.
`ifndef SIZE_ADDR
`define SIZE_ADDR 32
`endif

module tb_stg_ia;
  localparam int AW = `SIZE_ADDR;
  localparam int NB = 4;
  localparam logic [AW-1:0] RPC = AW'(32'h10);

  logic          iw_clk = 1'b0;
  logic          iw_rst = 1'b1;
  logic          iw_stall = 1'b0;
  logic          iw_redirect = 1'b0;
  logic [AW-1:0] iw_redirect_pc = '0;
  logic          iw_halt = 1'b0;
  logic          iw_btb_we = 1'b0;
  logic          iw_btb_inval = 1'b0;
  logic [AW-1:0] iw_btb_pc = '0;
  logic [AW-1:0] iw_btb_target = '0;
  logic [AW-1:0] ow_mem_addr, ow_pc, ow_pred_target;
  logic          ow_ia_valid, ow_pred_taken;

  int checks = 0;
  int errors = 0;

  stg_ia #(.RESET_PC(RPC), .BTB_ENTRIES(NB)) dut (
    .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_stall(iw_stall),
    .iw_redirect(iw_redirect), .iw_redirect_pc(iw_redirect_pc), .iw_halt(iw_halt),
    .iw_btb_we(iw_btb_we), .iw_btb_inval(iw_btb_inval), .iw_btb_pc(iw_btb_pc),
    .iw_btb_target(iw_btb_target), .ow_mem_addr(ow_mem_addr), .ow_pc(ow_pc),
    .ow_ia_valid(ow_ia_valid), .ow_pred_taken(ow_pred_taken), .ow_pred_target(ow_pred_target)
  );

  always #5 iw_clk = ~iw_clk;

  // Reference model: tracks the fetch PC and a table of remembered branch PCs per slot.
  logic [AW-1:0] m_pc;
  logic          m_valid, m_in_reset, m_halted, m_known = 1'b0;
  logic          m_bv [NB];
  logic [AW-1:0] m_bpc [NB];
  logic [AW-1:0] m_btgt [NB];

  function automatic int slot(input logic [AW-1:0] pc);
    return int'(pc % NB);
  endfunction

  function automatic logic m_hit(input logic [AW-1:0] pc);
`ifdef STG_IA_BTB_EN
    return m_bv[slot(pc)] && (m_bpc[slot(pc)] == pc);
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge iw_clk) begin
    if (iw_rst) begin
      m_pc = RPC; m_valid = 1'b0; m_in_reset = 1'b1; m_halted = 1'b0;
      for (int i = 0; i < NB; i++) m_bv[i] = 1'b0;
    end else begin
      if (m_in_reset) begin
        m_in_reset = 1'b0; m_valid = 1'b1;
      end else if (iw_redirect) begin
        m_pc = iw_redirect_pc; m_valid = 1'b1; m_halted = 1'b0;
      end else if (m_halted || iw_stall) begin
        m_pc = m_pc;
      end else if (iw_halt) begin
        m_halted = 1'b1; m_valid = 1'b0;
      end else if (m_hit(m_pc)) begin
        m_pc = m_btgt[slot(m_pc)];
      end else begin
        m_pc = m_pc + 1;
      end
      if (iw_btb_we) begin
        m_bv[slot(iw_btb_pc)] = 1'b1;
        m_bpc[slot(iw_btb_pc)] = iw_btb_pc;
        m_btgt[slot(iw_btb_pc)] = iw_btb_target;
      end else if (iw_btb_inval && m_bpc[slot(iw_btb_pc)] == iw_btb_pc) begin
        m_bv[slot(iw_btb_pc)] = 1'b0;
      end
    end
    m_known = 1'b1;
  end

  always @(negedge iw_clk) begin
    if (m_known) begin
      logic          e_hit;
      logic [AW-1:0] e_tgt;
      e_hit = m_hit(m_pc);
      e_tgt = e_hit ? m_btgt[slot(m_pc)] : '0;
      checks++;
      if (ow_pc !== m_pc || ow_mem_addr !== m_pc || ow_ia_valid !== m_valid ||
          ow_pred_taken !== e_hit || ow_pred_target !== e_tgt) begin
        errors++;
        $display("FAIL model t=%0t: got pc=%h addr=%h v=%b pt=%b ptg=%h, want pc=%h v=%b pt=%b ptg=%h",
                 $time, ow_pc, ow_mem_addr, ow_ia_valid, ow_pred_taken, ow_pred_target,
                 m_pc, m_valid, e_hit, e_tgt);
      end
    end
  end

  task automatic tick();
    @(posedge iw_clk);
    #1;
  endtask

  task automatic idle();
    iw_rst = 0; iw_stall = 0; iw_redirect = 0; iw_halt = 0;
    iw_btb_we = 0; iw_btb_inval = 0;
  endtask

  task automatic lit(input string nm, input logic [AW-1:0] epc, input logic ev);
    checks++;
    if (ow_pc !== epc || ow_ia_valid !== ev) begin
      errors++;
      $display("FAIL %s: got pc=%h valid=%b, want pc=%h valid=%b", nm, ow_pc, ow_ia_valid, epc, ev);
    end else
      $display("%s pc=%h valid=%b", nm, ow_pc, ow_ia_valid);
  endtask

  task automatic lit_pred(input string nm, input logic et, input logic [AW-1:0] etgt);
    checks++;
    if (ow_pred_taken !== et || ow_pred_target !== etgt) begin
      errors++;
      $display("FAIL %s: got taken=%b target=%h, want taken=%b target=%h",
               nm, ow_pred_taken, ow_pred_target, et, etgt);
    end else
      $display("%s taken=%b target=%h", nm, ow_pred_taken, ow_pred_target);
  endtask

  task automatic redirect_to(input logic [AW-1:0] a);
    iw_redirect = 1; iw_redirect_pc = a;
  endtask

  initial begin
    iw_rst = 1;
    tick(); lit("reset", AW'(32'h10), 0); lit_pred("reset_pred", 0, '0);
    idle();
    tick(); lit("run0", AW'(32'h10), 1);
    tick(); lit("run1", AW'(32'h11), 1);
    tick(); lit("run2", AW'(32'h12), 1);

    iw_stall = 1;
    for (int i = 0; i < 3; i++) begin tick(); lit("stall", AW'(32'h12), 1); end
    iw_stall = 0;
    tick(); lit("stall_rel", AW'(32'h13), 1);

    iw_stall = 1; redirect_to(AW'(32'h40));
    tick(); lit("redir_stall", AW'(32'h40), 1);
    idle();

    redirect_to(AW'(32'h20));
    tick(); lit("redir20", AW'(32'h20), 1);
    idle(); iw_halt = 1;
    tick(); lit("halt", AW'(32'h20), 0);
    iw_halt = 0;
    for (int i = 0; i < 4; i++) begin
      iw_stall = i[0];
      tick(); lit("halt_hold", AW'(32'h20), 0);
    end
    iw_stall = 1; iw_halt = 1; redirect_to(AW'(32'h80));
    tick(); lit("halt_redir", AW'(32'h80), 1);
    idle();
    tick(); lit("after_halt", AW'(32'h81), 1);

    redirect_to('1);
    tick(); lit("ones", '1, 1);
    idle();
    tick(); lit("wrap", '0, 1);

    iw_rst = 1; iw_stall = 1; iw_halt = 1; redirect_to(AW'(32'h55));
    tick(); lit("rst_mid", AW'(32'h10), 0);
    idle();
    tick(); lit("rst_mid_run", AW'(32'h10), 1);

    // Branch at 0x05 predicted to 0x30 (or ignored in the default build).
    iw_btb_we = 1; iw_btb_pc = AW'(32'h05); iw_btb_target = AW'(32'h30);
    redirect_to(AW'(32'h04));
    tick(); lit("btb_p4", AW'(32'h04), 1); lit_pred("btb_p4_pred", 0, '0);
    idle();
    tick(); lit("btb_p5", AW'(32'h05), 1);
`ifdef STG_IA_BTB_EN
    lit_pred("btb_hit", 1, AW'(32'h30));
    tick(); lit("btb_tgt", AW'(32'h30), 1);

    // Invalidate with a non-matching tag must keep the entry.
    iw_btb_inval = 1; iw_btb_pc = AW'(32'h09); redirect_to(AW'(32'h04));
    tick(); lit("inv_miss_p4", AW'(32'h04), 1);
    idle();
    tick(); lit_pred("inv_miss_keep", 1, AW'(32'h30));

    iw_btb_inval = 1; iw_btb_pc = AW'(32'h05); redirect_to(AW'(32'h04));
    tick(); lit("inv_p4", AW'(32'h04), 1);
    idle();
    tick(); lit("inv_p5", AW'(32'h05), 1); lit_pred("inv_nohit", 0, '0);
    tick(); lit("inv_p6", AW'(32'h06), 1);

    iw_btb_we = 1; iw_btb_inval = 1; iw_btb_pc = AW'(32'h05); iw_btb_target = AW'(32'h30);
    redirect_to(AW'(32'h09));
    tick(); lit("alias_p9", AW'(32'h09), 1); lit_pred("alias_nohit", 0, '0);
    idle();
    tick(); lit("alias_pa", AW'(32'h0a), 1);
    redirect_to(AW'(32'h05));
    tick(); lit_pred("we_wins", 1, AW'(32'h30));
    idle(); iw_stall = 1;
    tick(); lit("hit_stall", AW'(32'h05), 1);
    iw_stall = 0;
    tick(); lit("hit_after_stall", AW'(32'h30), 1);
`else
    lit_pred("nobtb_p5", 0, '0);
    tick(); lit("nobtb_p6", AW'(32'h06), 1);
`endif
    idle();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
